// File: rtl/pipe_adder_pkg.sv
// Shared constants, issue-FSM state type and width helper for the adder scheduler.
package pipe_adder_pkg;

  localparam int DATA_W     = 8;
  localparam int MAX_STAGES = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    HOLD_C
  } issue_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/phase_sync.sv
// Multi-flop synchronizer for one two-phase handshake wire; STAGES must be at least 2.
module phase_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pipe_adder_sched.sv
// Round-robin front-end sharing one self-timed three-operand adder among N clocked requesters.
// state    | meaning
// IDLE     | may grant one requester; operands latched and tag pushed on the grant edge
// ISSUE    | operands settled for one clock; pipe_Rin toggles leaving this state
// WAIT_ACK | waiting for synchronized pipe_Ain to match pipe_Rin
// HOLD_C   | operands frozen while the adder picks up c one stage late
module pipe_adder_sched
  import pipe_adder_pkg::*;
#(
  parameter int N            = 4,
  parameter int IDW          = clog2(N),
  parameter int MAX_INFLIGHT = 3,
  parameter int SYNC_STAGES  = 2,
  parameter int C_HOLD_CYC   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req_valid,
  output logic [N-1:0]        req_ready,
  input  logic [DATA_W*N-1:0] req_a,
  input  logic [DATA_W*N-1:0] req_b,
  input  logic [DATA_W*N-1:0] req_c,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [DATA_W-1:0]   rsp_sum,
  output logic [DATA_W-1:0]   pipe_a,
  output logic [DATA_W-1:0]   pipe_b,
  output logic [DATA_W-1:0]   pipe_c,
  output logic                pipe_Rin,
  input  logic                pipe_Ain,
  input  logic                pipe_Rout,
  output logic                pipe_Aout,
  input  logic [DATA_W-1:0]   pipe_out
);

  localparam int             HCW       = clog2(C_HOLD_CYC + 1);
  localparam logic [HCW-1:0] HOLD_LOAD = HCW'(C_HOLD_CYC);
  localparam logic [1:0]     INFL_MAX  = 2'(MAX_INFLIGHT);
  localparam int             TAG_DEPTH = MAX_STAGES + 1;

  issue_state_t   state_q, state_d;
  logic           rin_q, aout_q, ain_s, rout_s;
  logic [1:0]     inflight_q;
  logic [HCW-1:0] hold_q;
  logic [IDW-1:0] last_q, winner;
  logic           grant, push, pending, capture, issue_now;
  logic [IDW-1:0] tag_mem [TAG_DEPTH];
  logic [1:0]     wr_ptr, rd_ptr;
  logic [2:0]     tag_cnt;

  phase_sync #(.STAGES(SYNC_STAGES)) u_sync_ain (
    .clk (clk), .rst (rst), .d (pipe_Ain), .q (ain_s)
  );

  phase_sync #(.STAGES(SYNC_STAGES)) u_sync_rout (
    .clk (clk), .rst (rst), .d (pipe_Rout), .q (rout_s)
  );

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
    return IDW'((int'(base) + k) % N);
  endfunction

  // search starts one past the previous winner so every requester gets a turn
  always_comb begin
    grant  = 1'b0;
    winner = '0;
    if (!rst && state_q == IDLE && inflight_q < INFL_MAX) begin
      for (int k = 1; k <= N; k++) begin
        if (!grant && req_valid[rr_idx(last_q, k)]) begin
          grant  = 1'b1;
          winner = rr_idx(last_q, k);
        end
      end
    end
  end

  assign req_ready = grant ? (N'(1) << winner) : '0;
  assign push      = grant;
  assign issue_now = (state_q == ISSUE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (grant) state_d = ISSUE;
      ISSUE:    state_d = WAIT_ACK;
      WAIT_ACK: if (ain_s == rin_q) state_d = HOLD_C;
      HOLD_C:   if (hold_q == '0) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rin_q   <= 1'b0;
      last_q  <= IDW'(N - 1);
      hold_q  <= '0;
      pipe_a  <= '0;
      pipe_b  <= '0;
      pipe_c  <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        pipe_a <= req_a[winner*DATA_W +: DATA_W];
        pipe_b <= req_b[winner*DATA_W +: DATA_W];
        pipe_c <= req_c[winner*DATA_W +: DATA_W];
        last_q <= winner;
      end
      if (issue_now) rin_q <= ~rin_q;
      if (state_q == WAIT_ACK && ain_s == rin_q) hold_q <= HOLD_LOAD;
      else if (state_q == HOLD_C && hold_q != '0) hold_q <= hold_q - HCW'(1);
    end
  end

  assign pending = (rout_s != aout_q);
  assign capture = pending && (!rsp_valid || rsp_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_sum    <= '0;
      rsp_id     <= '0;
      aout_q     <= 1'b0;
      inflight_q <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tag_cnt    <= '0;
    end else begin
      if (capture) begin
        rsp_sum   <= pipe_out;
        rsp_id    <= tag_mem[rd_ptr];
        rsp_valid <= 1'b1;
        aout_q    <= ~aout_q;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      case ({issue_now, capture})
        2'b10:   inflight_q <= inflight_q + 2'd1;
        2'b01:   inflight_q <= inflight_q - 2'd1;
        default: inflight_q <= inflight_q;
      endcase
      if (push)    wr_ptr <= wr_ptr + 2'd1;
      if (capture) rd_ptr <= rd_ptr + 2'd1;
      case ({push, capture})
        2'b10:   tag_cnt <= tag_cnt + 3'd1;
        2'b01:   tag_cnt <= tag_cnt - 3'd1;
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= winner;
  end

  assign pipe_Rin  = rin_q;
  assign pipe_Aout = aout_q;

  // adder is FIFO-ordered, so a result can never arrive without a queued tag
  tag_underflow: assert property (@(posedge clk) disable iff (rst) !(pending && tag_cnt == '0));

endmodule

// File: doc/pipe_adder_sched.md
Name: pipe_adder_sched

Overview:
- Synchronous front-end that shares one asynchronous three-operand pipelined adder (a+b in stage 1, +c in stage 2, 3 event-register stages) among N clocked requesters.
- Arbitrates round-robin and drives the adder's two-phase bundled-data input handshake (Rin/Ain). Collects results through the output handshake (Rout/Aout) and returns each sum tagged with the originating requester ID.
- Sits between the clocked bus domain and the self-timed adder.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, 2, requester-ID width, equals clog2(N).
- MAX_INFLIGHT, 3, maximum tokens inside the adder, 1..3.
- SYNC_STAGES, 2, flops per phase synchronizer for pipe_Ain and pipe_Rout.
- C_HOLD_CYC, 4, clk cycles pipe_c is held stable after synchronized Ain is seen.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  N  per-requester operand valid.
- req_ready  out  N  per-requester accept, one-hot or zero.
- req_a  in  8*N  operand a, slice i belongs to requester i.
- req_b  in  8*N  operand b.
- req_c  in  8*N  operand c.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumer accept.
- rsp_id  out  IDW  requester that issued the result.
- rsp_sum  out  8  (a+b+c) mod 256.
- pipe_a / pipe_b / pipe_c  out  8 each  operands to adder.
- pipe_Rin  out  1  two-phase input request, toggles once per token.
- pipe_Ain  in  1  two-phase input ack, asynchronous.
- pipe_Rout  in  1  two-phase output request, asynchronous.
- pipe_Aout  out  1  two-phase output ack, toggles once per result.
- pipe_out  in  8  adder result, bundled with pipe_Rout.

Behaviour:
- Reset: all outputs 0. Phases rin_q=aout_q=0, inflight=0, tag FIFO empty, RR pointer selects requester 0 first, synchronizers cleared. Adder rst is the same system rst; both sides restart at phase 0.
- Reset mid-operation: all in-flight tokens and any held response are discarded with no rsp_valid. Issue/return FSMs return to IDLE / no pending result.
- Synchronizers: ain_s, rout_s are SYNC_STAGES-flop samples of pipe_Ain and pipe_Rout.
- Issue FSM states:
  - IDLE: grant when any req_valid and inflight<MAX_INFLIGHT. Winner is the first valid index after the last grant, wrapping. req_ready[winner]=1 for exactly that cycle. Next edge: latch pipe_a/b/c from winner's slices, push winner ID into tag FIFO, go to ISSUE.
  - ISSUE (1 cycle): toggle pipe_Rin. Operands are set up ≥1 clk before the edge (bundling). inflight++. Go to WAIT_ACK.
  - WAIT_ACK: wait for ain_s == rin_q, then load hold counter = C_HOLD_CYC and go to HOLD_C.
  - HOLD_C: pipe_a/b/c stay frozen. The adder captures c one stage later than a/b, so c must stay stable. Counter decrements each cycle; at 0 go to IDLE.
- No new grant in ISSUE, WAIT_ACK or HOLD_C. Single-cycle throughput is not a goal; latency grant→Rin toggle = 2 clk.
- Return path:
  - Result pending when rout_s != aout_q.
  - Capture when pending and the response slot is free, or is being drained this cycle (rsp_valid && rsp_ready).
  - On capture: rsp_sum<=pipe_out, rsp_id<=tag FIFO head (pop), rsp_valid<=1, toggle pipe_Aout, inflight--.
  - Data is valid at capture: pipe_out is stable before the Rout transition and held until Aout toggles.
- Backpressure: if rsp_valid && !rsp_ready, no capture and Aout is not toggled. The adder stalls through its own handshake.
- rsp_valid drops after the rsp_ready handshake unless a new capture happens the same cycle.
- Simultaneous issue and capture: inflight unchanged. FIFO push and pop in the same cycle are legal, including when full at MAX_INFLIGHT.
- Order: the adder is FIFO-ordered, so tag FIFO head always matches the result.
- Arithmetic: 8-bit wrap, no carry out.
- Errors: a pending result with an empty tag FIFO cannot occur. Assertion only.

Decomposition:
- Package pipe_adder_pkg holds DATA_W=8, max stage count 3, issue-FSM state enum {IDLE, ISSUE, WAIT_ACK, HOLD_C}, and the clog2 helper for IDW.
- One sub-module: phase_sync (SYNC_STAGES-deep single-bit synchronizer, async rst clears), instanced for pipe_Ain and pipe_Rout.
- Tag FIFO and RR arbiter stay inline.

Test Plan:
- Single request: req0 a=3,b=4,c=5 → Rin toggles 0→1 two cycles after grant; rsp_sum=12, rsp_id=0; Aout toggles 0→1; inflight returns to 0.
- Overflow: a=200,b=100,c=10 → rsp_sum=54.
- Round-robin: all 4 requesters valid continuously → grants in order 0,1,2,3,0. Responses carry ids 0,1,2,3 in issue order.
- Inflight limit: MAX_INFLIGHT=3, slow adder model (Rout delay 200ns), rsp_ready=1 → 4th grant withheld until the first result is captured. inflight never exceeds 3.
- Backpressure: rsp_ready=0 for 50 cycles with 3 tokens queued → only one rsp held, Aout toggles once, no data lost. Release yields 3 sums in order.
- C hold: the adder model samples pipe_c 3 clk after Ain → correct sum. Bench flags any pipe_c change inside the HOLD_C window.
- Reset mid-flight: assert rst with 2 tokens inflight → all outputs 0 and no rsp_valid. Next transaction after release completes correctly.
